jtag_cmd_fifo: RTL and testbench

Upstream feeder of the JTAG sequencer. It takes the MCU's byte stream (from the SPI slave bridge) and assembles variable-length command records. Assembled records go into a first-word-fall-through (FWFT) FIFO that drives the sequencer's out_seq_* interface. It also tracks protocol errors: unknown command codes and reads while empty.

---
 rtl/jtag_cmd_fifo_pkg.sv | 41 ++++
 rtl/jtag_cmd_fifo_if.sv | 27 ++
 rtl/jtag_cmd_fifo_mem.sv | 69 ++++++
 rtl/jtag_cmd_fifo.sv | 131 +++++++++++++
 tb/tb_jtag_cmd_fifo.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_cmd_fifo_pkg.sv
// Shared definitions for the JTAG command FIFO: command codes, assembler states,
// record lengths and the stored entry layout.
package jtag_cmd_fifo_pkg;

  localparam int unsigned DEPTH_LOG2 = 9;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned ENTRY_W    = 29;

  localparam logic [4:0] FIFO_CMD_WR      = 5'd1;
  localparam logic [4:0] FIFO_CMD_STORE   = 5'd2;
  localparam logic [4:0] FIFO_CMD_EXECUTE = 5'd3;
  localparam logic [4:0] FIFO_CMD_FLUSH   = 5'd4;

  localparam int unsigned REC_LEN_WR      = 4;
  localparam int unsigned REC_LEN_STORE   = 3;
  localparam int unsigned REC_LEN_EXECUTE = 1;
  localparam int unsigned REC_LEN_FLUSH   = 1;

  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_TMS = 2'd1,
    ST_TDI = 2'd2,
    ST_RD  = 2'd3
  } asm_state_e;

  typedef struct packed {
    logic [4:0] command;
    logic [2:0] bits;
    logic [7:0] tms;
    logic [7:0] tdi;
    logic [4:0] read;
  } seq_entry_t;

  // Full when the pointers index the same slot but sit on opposite wraps.
  function automatic logic ptr_full(input logic [DEPTH_LOG2:0] w,
                                    input logic [DEPTH_LOG2:0] r);
    return (w[DEPTH_LOG2] != r[DEPTH_LOG2]) &&
           (w[DEPTH_LOG2-1:0] == r[DEPTH_LOG2-1:0]);
  endfunction

endpackage

// File: rtl/jtag_cmd_fifo_if.sv
// Byte-input and sequencer-output handshake bundle of the JTAG command FIFO.
interface jtag_cmd_fifo_if;

  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic       out_seq_empty;
  logic [4:0] out_seq_command;
  logic [2:0] out_seq_bits;
  logic [7:0] out_seq_tms;
  logic [7:0] out_seq_tdi;
  logic [7:0] out_seq_read;
  logic       out_seq_re;

  modport master (
    output in_byte, in_valid, out_seq_re,
    input  in_ready, out_seq_empty, out_seq_command, out_seq_bits,
           out_seq_tms, out_seq_tdi, out_seq_read
  );

  modport slave (
    input  in_byte, in_valid, out_seq_re,
    output in_ready, out_seq_empty, out_seq_command, out_seq_bits,
           out_seq_tms, out_seq_tdi, out_seq_read
  );

endinterface

// File: rtl/jtag_cmd_fifo_mem.sv
// Sync-write/sync-read record RAM with a first-word-fall-through output register.
// JTAG_CMD_FIFO_LEVEL_EN adds the registered occupancy output.
module jtag_cmd_fifo_mem
  import jtag_cmd_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       wr_en,
  input  seq_entry_t wr_data,
  input  logic       rd_en,
  output logic       out_empty,
  output seq_entry_t out_data,
  output logic       not_full
`ifdef JTAG_CMD_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level
`endif
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

  logic [ENTRY_W-1:0] ram [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_next;
  logic [PTR_W-1:0]   rd_next;
  logic               wr_go;
  logic               pop;
  logic               avail;

  // rd_ptr addresses the presented record, so occupancy includes it.
  always_comb begin
    wr_go   = wr_en && !rst && !clear;
    pop     = rd_en && !out_empty;
    wr_next = wr_ptr + PTR_W'(wr_go);
    rd_next = rd_ptr + PTR_W'(pop);
    avail   = (wr_ptr != rd_next);
  end

  always_ff @(posedge clk) begin
    if (wr_go) ram[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_empty <= 1'b1;
      out_data  <= '0;
      not_full  <= !rst;
`ifdef JTAG_CMD_FIFO_LEVEL_EN
      level     <= '0;
`endif
    end else begin
      wr_ptr   <= wr_next;
      rd_ptr   <= rd_next;
      not_full <= !ptr_full(wr_next, rd_next);
      if (out_empty || pop) begin
        out_empty <= !avail;
        if (avail) out_data <= ram[rd_next[DEPTH_LOG2-1:0]];
      end
`ifdef JTAG_CMD_FIFO_LEVEL_EN
      level    <= wr_next - rd_next;
`endif
    end
  end

endmodule

// File: rtl/jtag_cmd_fifo.sv
// Assembles MCU byte stream into sequencer command records and queues them in an FWFT FIFO.
// JTAG_CMD_FIFO_LEVEL_EN exposes the FIFO occupancy on fifo_level.
module jtag_cmd_fifo
  import jtag_cmd_fifo_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  jtag_cmd_fifo_if.slave      seq,
`ifdef JTAG_CMD_FIFO_LEVEL_EN
  output logic [DEPTH_LOG2:0] fifo_level,
`endif
  output logic                err_unknown_cmd,
  output logic                err_underflow
);

  asm_state_e state;
  logic [4:0] cmd_q;
  logic [2:0] bits_q;
  logic [7:0] tms_q;
  logic [7:0] tdi_q;
  logic [4:0] hdr_cmd;
  logic       accept;
  logic       commit;
  logic       unknown;
  logic       hdr_long;
  seq_entry_t entry;
  seq_entry_t out_data;
  logic       out_empty;
  logic       not_full;

  // Decode the accepted byte; the byte that completes a record commits it.
  always_comb begin
    accept   = seq.in_valid && seq.in_ready && !clear;
    hdr_cmd  = seq.in_byte[4:0];
    commit   = 1'b0;
    unknown  = 1'b0;
    hdr_long = 1'b0;
    entry    = '0;
    if (accept) begin
      case (state)
        ST_HDR: begin
          entry.command = hdr_cmd;
          entry.bits    = seq.in_byte[7:5];
          if (hdr_cmd == FIFO_CMD_WR || hdr_cmd == FIFO_CMD_STORE) hdr_long = 1'b1;
          else if (hdr_cmd == FIFO_CMD_EXECUTE || hdr_cmd == FIFO_CMD_FLUSH) commit = 1'b1;
          else unknown = 1'b1;
        end
        ST_TDI: begin
          commit        = (cmd_q == FIFO_CMD_STORE);
          entry.command = cmd_q;
          entry.bits    = bits_q;
          entry.tms     = tms_q;
          entry.tdi     = seq.in_byte;
        end
        ST_RD: begin
          commit        = 1'b1;
          entry.command = cmd_q;
          entry.bits    = bits_q;
          entry.tms     = tms_q;
          entry.tdi     = tdi_q;
          entry.read    = seq.in_byte[4:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state  <= ST_HDR;
      cmd_q  <= '0;
      bits_q <= '0;
      tms_q  <= '0;
      tdi_q  <= '0;
    end else if (accept) begin
      case (state)
        ST_HDR: begin
          cmd_q  <= hdr_cmd;
          bits_q <= seq.in_byte[7:5];
          if (hdr_long) state <= ST_TMS;
        end
        ST_TMS: begin
          tms_q <= seq.in_byte;
          state <= ST_TDI;
        end
        ST_TDI: begin
          tdi_q <= seq.in_byte;
          state <= (cmd_q == FIFO_CMD_STORE) ? ST_HDR : ST_RD;
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  // Sticky protocol errors survive clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unknown_cmd <= 1'b0;
      err_underflow   <= 1'b0;
    end else begin
      if (unknown) err_unknown_cmd <= 1'b1;
      if (seq.out_seq_re && out_empty) err_underflow <= 1'b1;
    end
  end

  jtag_cmd_fifo_mem u_mem (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .wr_en     (commit),
    .wr_data   (entry),
    .rd_en     (seq.out_seq_re),
    .out_empty (out_empty),
    .out_data  (out_data),
    .not_full  (not_full)
`ifdef JTAG_CMD_FIFO_LEVEL_EN
    ,
    .level     (fifo_level)
`endif
  );

  assign seq.in_ready        = not_full;
  assign seq.out_seq_empty   = out_empty;
  assign seq.out_seq_command = out_data.command;
  assign seq.out_seq_bits    = out_data.bits;
  assign seq.out_seq_tms     = out_data.tms;
  assign seq.out_seq_tdi     = out_data.tdi;
  assign seq.out_seq_read    = {3'b000, out_data.read};

endmodule

// File: tb/tb_jtag_cmd_fifo.sv
// Scoreboard bench for jtag_cmd_fifo: record-level reference model feeds an expected
// queue, an independent monitor pops and compares. Honours JTAG_CMD_FIFO_LEVEL_EN.
module tb_jtag_cmd_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic err_unknown_cmd;
  logic err_underflow;
`ifdef JTAG_CMD_FIFO_LEVEL_EN
  logic [9:0] fifo_level;
`endif

  always #5 clk = ~clk;

  jtag_cmd_fifo_if bus();

  jtag_cmd_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .seq             (bus),
`ifdef JTAG_CMD_FIFO_LEVEL_EN
    .fifo_level      (fifo_level),
`endif
    .err_unknown_cmd (err_unknown_cmd),
    .err_underflow   (err_underflow)
  );

  typedef struct {
    logic [4:0] cmd;
    logic [2:0] bits;
    logic [7:0] tms;
    logic [7:0] tdi;
    logic [7:0] rd;
  } rec_t;

  rec_t exp_q[$];
  rec_t no_rec;
  int   vectors     = 0;
  int   miscompares = 0;
  int   pop_prob    = 0;
  int   model_cnt   = 0;
  bit   force_re    = 1'b0;
  bit   commit_now  = 1'b0;
  bit   pop_now     = 1'b0;
  bit   gap_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Occupancy model: records committed minus records popped, zeroed by rst/clear.
  initial forever begin
    @(posedge clk);
    if (rst || clear) model_cnt = 0;
    else model_cnt = model_cnt + (commit_now ? 1 : 0) - (pop_now ? 1 : 0);
  end

  // Consumer and monitor: decides out_seq_re and checks every popped record.
  initial forever begin
    rec_t e;
    @(negedge clk);
    #1;
    pop_now = 1'b0;
    if (rst) begin
      bus.out_seq_re = 1'b0;
    end else begin
      bus.out_seq_re = force_re ||
                       (!bus.out_seq_empty && (int'($urandom_range(0, 99)) < pop_prob));
      if (bus.out_seq_re && !bus.out_seq_empty) begin
        pop_now = 1'b1;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_record: got cmd 0x%0h, want no record", bus.out_seq_command);
        end else begin
          e = exp_q.pop_front();
          check("pop_command", 32'(bus.out_seq_command), 32'(e.cmd));
          check("pop_bits",    32'(bus.out_seq_bits),    32'(e.bits));
          check("pop_tms",     32'(bus.out_seq_tms),     32'(e.tms));
          check("pop_tdi",     32'(bus.out_seq_tdi),     32'(e.tdi));
          check("pop_read",    32'(bus.out_seq_read),    32'(e.rd));
        end
      end
`ifdef JTAG_CMD_FIFO_LEVEL_EN
      check("fifo_level", 32'(fifo_level), 32'(model_cnt));
`endif
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit last, input rec_t e);
    int t = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready 0, want 1 within 4000 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    if (last) begin
      exp_q.push_back(e);
      commit_now = 1'b1;
    end
    @(negedge clk);
    commit_now   = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic gap();
    if (gap_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // kind: 0 WR, 1 STORE, 2 EXECUTE, 3 FLUSH
  task automatic send_rec(input int kind, input logic [2:0] bits,
                          input logic [7:0] tms, input logic [7:0] tdi, input logic [7:0] rd);
    rec_t e;
    logic [4:0] code;
    logic [7:0] rd_v;
    rd_v   = rd;
    code   = (kind == 0) ? 5'd1 : (kind == 1) ? 5'd2 : (kind == 2) ? 5'd3 : 5'd4;
    e.cmd  = code;
    e.bits = bits;
    e.tms  = (kind <= 1) ? tms : 8'h00;
    e.tdi  = (kind <= 1) ? tdi : 8'h00;
    e.rd   = (kind == 0) ? {3'b000, rd_v[4:0]} : 8'h00;
    gap(); send_byte({bits, code}, kind >= 2, e);
    if (kind <= 1) begin
      gap(); send_byte(tms, 1'b0, e);
      gap(); send_byte(tdi, kind == 1, e);
    end
    if (kind == 0) begin
      gap(); send_byte(rd, 1'b1, e);
    end
  endtask

  task automatic send_rand_wr();
    send_rec(0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic wait_drain();
    int t = 0;
    pop_prob = 100;
    while ((exp_q.size() != 0 || !bus.out_seq_empty) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    pop_prob = 0;
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    check("drain_empty", 32'(bus.out_seq_empty), 32'd1);
  endtask

  initial begin
    int r;
    no_rec.cmd = '0; no_rec.bits = '0; no_rec.tms = '0; no_rec.tdi = '0; no_rec.rd = '0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_empty",    32'(bus.out_seq_empty),   32'd1);
    check("rst_in_ready", 32'(bus.in_ready),        32'd0);
    check("rst_command",  32'(bus.out_seq_command), 32'd0);
    check("rst_bits",     32'(bus.out_seq_bits),    32'd0);
    check("rst_tms",      32'(bus.out_seq_tms),     32'd0);
    check("rst_tdi",      32'(bus.out_seq_tdi),     32'd0);
    check("rst_read",     32'(bus.out_seq_read),    32'd0);
    check("rst_err_unk",  32'(err_unknown_cmd),     32'd0);
    check("rst_err_und",  32'(err_underflow),       32'd0);
`ifdef JTAG_CMD_FIFO_LEVEL_EN
    check("rst_level",    32'(fifo_level),          32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // WR record and two-edge presentation latency
    send_rec(0, 3'd3, 8'hA5, 8'h3C, 8'h01);
    check("wr_empty_at_commit", 32'(bus.out_seq_empty), 32'd1);
    @(negedge clk);
    check("wr_empty_next_edge", 32'(bus.out_seq_empty), 32'd0);
    check("wr_command", 32'(bus.out_seq_command), 32'h01);
    check("wr_bits",    32'(bus.out_seq_bits),    32'h3);
    check("wr_tms",     32'(bus.out_seq_tms),     32'hA5);
    check("wr_tdi",     32'(bus.out_seq_tdi),     32'h3C);
    check("wr_read",    32'(bus.out_seq_read),    32'h01);
    wait_drain();

    // STORE, EXECUTE, FLUSH in order
    send_rec(1, 3'd0, 8'h10, 8'h00, 8'h00);
    send_rec(2, 3'd0, 8'h00, 8'h00, 8'h00);
    send_rec(3, 3'd0, 8'h00, 8'h00, 8'h00);
    wait_drain();

    // Unknown command code
    check("unk_err_before", 32'(err_unknown_cmd), 32'd0);
    send_byte(8'h1F, 1'b0, no_rec);
    repeat (2) @(negedge clk);
    check("unk_err_after", 32'(err_unknown_cmd), 32'd1);
    check("unk_fifo_empty", 32'(bus.out_seq_empty), 32'd1);
    send_rand_wr();
    wait_drain();

    // Pop while empty
    check("und_err_before", 32'(err_underflow), 32'd0);
    force_re = 1'b1;
    @(negedge clk);
    force_re = 1'b0;
    @(negedge clk);
    check("und_err_after", 32'(err_underflow), 32'd1);
    check("und_still_empty", 32'(bus.out_seq_empty), 32'd1);
    check("und_in_ready", 32'(bus.in_ready), 32'd1);

    // clear drops queued and partial records, keeps errors
    send_rand_wr();
    send_rec(2, 3'd6, 8'h00, 8'h00, 8'h00);
    send_byte(8'h21, 1'b0, no_rec);
    send_byte(8'h55, 1'b0, no_rec);
    clear = 1'b1;
    exp_q.delete();
    @(negedge clk);
    clear = 1'b0;
    check("clr_empty", 32'(bus.out_seq_empty), 32'd1);
    check("clr_in_ready", 32'(bus.in_ready), 32'd1);
    check("clr_err_unk_kept", 32'(err_unknown_cmd), 32'd1);
    check("clr_err_und_kept", 32'(err_underflow), 32'd1);
    send_rec(0, 3'd5, 8'h5A, 8'hC3, 8'hFF);
    wait_drain();

    // Random streaming with concurrent pops
    pop_prob = 50;
    gap_en   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 9) begin
        r = int'($urandom_range(0, 27));
        gap();
        send_byte({3'($urandom_range(0, 7)), (r == 0) ? 5'd0 : 5'(r + 4)}, 1'b0, no_rec);
      end else begin
        send_rec((r <= 4) ? 0 : (r <= 6) ? 1 : (r == 7) ? 2 : 3,
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
    end
    gap_en = 1'b0;
    wait_drain();

    // Fill to full, single pop, then drain back-to-back across the wrap
    pop_prob = 0;
    for (int i = 0; i < 512; i++) send_rand_wr();
    repeat (2) @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_not_empty", 32'(bus.out_seq_empty), 32'd0);
    force_re = 1'b1;
    check("full_in_ready_pop_cycle", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    force_re = 1'b0;
    check("in_ready_after_pop", 32'(bus.in_ready), 32'd1);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: got simulation still running, want completion before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
